// File: rtl/raster_to_block_if.sv
// raster_to_block_if: raster pixel input stream, frame geometry and block-ordered output
// stream of the raster-to-block reorder stage. The master drives pixels, the slave
// (the reorder stage) drives the block stream.
interface raster_to_block_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [15:0]           frame_width;
    logic [15:0]           frame_height;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sof;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;
    logic                  start_data;
    logic                  start_of_frame;
    logic                  end_of_frame;
    logic [31:0]           blocks_per_frame;
    logic                  frame_err;

    modport master (
        output frame_width, frame_height, in_valid, in_data, in_sof,
        input  in_ready, data_out, out_valid, start_data, start_of_frame, end_of_frame,
               blocks_per_frame, frame_err
    );

    modport slave (
        input  frame_width, frame_height, in_valid, in_data, in_sof,
        output in_ready, data_out, out_valid, start_data, start_of_frame, end_of_frame,
               blocks_per_frame, frame_err
    );
endinterface

// File: rtl/raster_to_block.sv
// raster_to_block: buffers BLOCK_SIZE raster rows in ping-pong banks and replays each
// strip as BLOCK_SIZE x BLOCK_SIZE blocks in row-major order, with block/frame framing.
// Optional feature macro: RASTER_TO_BLOCK_SOF_CHECK_EN (mid-frame SOF restarts the frame
// and pulses frame_err; otherwise mid-frame SOF is ignored and frame_err is 0).
module raster_to_block #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned MAX_WIDTH  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    raster_to_block_if.slave io_bus
);
    localparam int unsigned RW  = $clog2(BLOCK_SIZE);
    localparam int unsigned CW  = $clog2(MAX_WIDTH);
    localparam int unsigned BXW = CW - RW;
    localparam int unsigned AW  = 1 + RW + CW;
    localparam logic [RW-1:0] RowLast = RW'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {WIdle, WFill, WWait} wstate_e;
    typedef enum logic {RIdle, RStream} rstate_e;

    // Address layout {bank, row, column}; the read column is {block x, column in block}.
    logic [DATA_WIDTH-1:0] r_mem [2**AW];

    wstate_e          r_wstate;
    logic             r_in_ready;
    logic [RW-1:0]    r_wrow;
    logic [CW-1:0]    r_wcol;
    logic [15:0]      r_wstrip;
    logic             r_wbank;
    logic [CW-1:0]    r_width_m1;
    logic [BXW-1:0]   r_wbw_m1;
    logic [15:0]      r_strips_m1;
    logic [31:0]      r_bpf;

    rstate_e          r_rstate;
    logic [RW-1:0]    r_rrow;
    logic [RW-1:0]    r_rcol;
    logic [BXW-1:0]   r_rbx;
    logic [BXW-1:0]   r_rbw_m1;
    logic             r_rfirst;
    logic             r_rlast;

    logic [DATA_WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_start_data;
    logic             r_sof;
    logic             r_eof;

    logic             w_accept;
    logic             w_sof_err;
    logic             w_sof_start;
    logic             w_wr_last_px;
    logic             w_wr_last_strip;
    logic             w_rd_issue;
    logic             w_rd_last;
    logic             w_rd_free;
    logic             w_handoff;
    logic             w_we;
    logic [RW-1:0]    w_wrow;
    logic [CW-1:0]    w_wcol;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic [15:0]      w_fw_blk;
    logic [15:0]      w_fh_blk;
    logic [31:0]      w_bpf;

    assign w_accept = io_bus.in_valid & r_in_ready;

`ifdef RASTER_TO_BLOCK_SOF_CHECK_EN
    assign w_sof_err = w_accept & io_bus.in_sof & (r_wstate != WIdle);
`else
    assign w_sof_err = 1'b0;
`endif

    assign w_sof_start     = w_accept & io_bus.in_sof & ((r_wstate == WIdle) | w_sof_err);
    assign w_wr_last_px    = (r_wrow == RowLast) && (r_wcol == r_width_m1);
    assign w_wr_last_strip = (r_wstrip == r_strips_m1);

    assign w_rd_issue = (r_rstate == RStream);
    assign w_rd_last  = w_rd_issue && (r_rrow == RowLast) && (r_rcol == RowLast) &&
                        (r_rbx == r_rbw_m1);
    // A reader issuing its last address frees its bank in the same cycle.
    assign w_rd_free  = (r_rstate == RIdle) | w_rd_last;
    assign w_handoff  = ((r_wstate == WFill) & w_accept & ~w_sof_err & w_wr_last_px &
                         w_rd_free) | ((r_wstate == WWait) & w_rd_last);

    assign w_we    = w_sof_start | ((r_wstate == WFill) & w_accept);
    assign w_wrow  = w_sof_start ? '0 : r_wrow;
    assign w_wcol  = w_sof_start ? '0 : r_wcol;
    assign w_waddr = {r_wbank, w_wrow, w_wcol};
    assign w_raddr = {~r_wbank, r_rrow, r_rbx, r_rcol};

    assign w_fw_blk = io_bus.frame_width >> RW;
    assign w_fh_blk = io_bus.frame_height >> RW;
    assign w_bpf    = 32'(w_fw_blk) * 32'(w_fh_blk);

    // Write FSM: fill the write bank in raster order and hand it over at each strip end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate    <= WIdle;
            r_in_ready  <= 1'b0;
            r_wrow      <= '0;
            r_wcol      <= '0;
            r_wstrip    <= '0;
            r_wbank     <= 1'b0;
            r_width_m1  <= '0;
            r_wbw_m1    <= '0;
            r_strips_m1 <= '0;
            r_bpf       <= '0;
        end else begin
            r_in_ready <= 1'b1;
            if (w_sof_start) begin
                r_width_m1  <= CW'(io_bus.frame_width - 16'd1);
                r_wbw_m1    <= BXW'(w_fw_blk - 16'd1);
                r_strips_m1 <= w_fh_blk - 16'd1;
                r_bpf       <= w_bpf;
                r_wrow      <= '0;
                r_wcol      <= CW'(1);
                r_wstrip    <= '0;
                r_wstate    <= WFill;
            end else begin
                case (r_wstate)
                    WFill: begin
                        if (w_accept) begin
                            if (r_wcol == r_width_m1) begin
                                r_wcol <= '0;
                                if (r_wrow == RowLast) begin
                                    r_wrow <= '0;
                                    if (w_rd_free) begin
                                        r_wbank  <= ~r_wbank;
                                        r_wstrip <= r_wstrip + 16'd1;
                                        if (w_wr_last_strip) begin
                                            r_wstate <= WIdle;
                                        end
                                    end else begin
                                        r_wstate   <= WWait;
                                        r_in_ready <= 1'b0;
                                    end
                                end else begin
                                    r_wrow <= r_wrow + 1'b1;
                                end
                            end else begin
                                r_wcol <= r_wcol + 1'b1;
                            end
                        end
                    end
                    WWait: begin
                        if (w_rd_last) begin
                            r_wbank  <= ~r_wbank;
                            r_wstrip <= r_wstrip + 16'd1;
                            r_wstate <= w_wr_last_strip ? WIdle : WFill;
                        end else begin
                            r_in_ready <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Bank write port; contents need no reset since every read follows a full strip fill.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= io_bus.in_data;
        end
    end

    // Read FSM: walk the read bank block by block, one address per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= RIdle;
            r_rrow   <= '0;
            r_rcol   <= '0;
            r_rbx    <= '0;
            r_rbw_m1 <= '0;
            r_rfirst <= 1'b0;
            r_rlast  <= 1'b0;
        end else if (w_sof_err) begin
            r_rstate <= RIdle;
        end else if (w_handoff) begin
            r_rstate <= RStream;
            r_rrow   <= '0;
            r_rcol   <= '0;
            r_rbx    <= '0;
            // Geometry is captured per strip so a new frame's SOF cannot disturb it.
            r_rbw_m1 <= r_wbw_m1;
            r_rfirst <= (r_wstrip == 16'd0);
            r_rlast  <= w_wr_last_strip;
        end else if (w_rd_issue) begin
            if (r_rcol == RowLast) begin
                r_rcol <= '0;
                if (r_rrow == RowLast) begin
                    r_rrow <= '0;
                    if (r_rbx == r_rbw_m1) begin
                        r_rbx    <= '0;
                        r_rstate <= RIdle;
                    end else begin
                        r_rbx <= r_rbx + 1'b1;
                    end
                end else begin
                    r_rrow <= r_rrow + 1'b1;
                end
            end else begin
                r_rcol <= r_rcol + 1'b1;
            end
        end
    end

    // Registered RAM read; data lands one cycle after its address is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_issue) begin
            r_data_out <= r_mem[w_raddr];
        end
    end

    // Framing flags delayed by one stage so they line up with data_out.
    always_ff @(posedge clk) begin
        if (rst || w_sof_err) begin
            r_out_valid  <= 1'b0;
            r_start_data <= 1'b0;
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;
        end else begin
            r_out_valid  <= w_rd_issue;
            r_start_data <= w_rd_issue && (r_rrow == '0) && (r_rcol == '0);
            r_sof        <= w_rd_issue && (r_rrow == '0) && (r_rcol == '0) &&
                            (r_rbx == '0) && r_rfirst;
            r_eof        <= w_rd_last && r_rlast;
        end
    end

`ifdef RASTER_TO_BLOCK_SOF_CHECK_EN
    logic r_frame_err;

    // One-cycle error pulse for an SOF that arrives mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_sof_err;
        end
    end

    assign io_bus.frame_err = r_frame_err;
`else
    assign io_bus.frame_err = 1'b0;
`endif

    assign io_bus.in_ready         = r_in_ready;
    assign io_bus.data_out         = r_data_out;
    assign io_bus.out_valid        = r_out_valid;
    assign io_bus.start_data       = r_start_data;
    assign io_bus.start_of_frame   = r_sof;
    assign io_bus.end_of_frame     = r_eof;
    assign io_bus.blocks_per_frame = r_bpf;
endmodule

// File: tb/tb_raster_to_block.sv
// tb_raster_to_block: directed bench for raster_to_block with B=8 and pixel value
// (16y+x) mod 256. Captured output is compared against a raster->block index model.
module tb_raster_to_block;
    localparam int B   = 8;
    localparam int CAP = 4096;

    typedef struct {
        int         idx;
        logic [7:0] data;
        bit         sd;
        bit         sof;
        bit         eof;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    raster_to_block_if #(.DATA_WIDTH(8)) bus ();

    raster_to_block #(
        .DATA_WIDTH(8),
        .BLOCK_SIZE(B),
        .MAX_WIDTH (1024)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] cap_data [CAP];
    bit         cap_sd   [CAP];
    bit         cap_sof  [CAP];
    bit         cap_eof  [CAP];
    int         cap_cyc  [CAP];
    int         cap_n    = 0;
    int         err_cnt  = 0;
    logic [7:0] exp_px   [512];
    int         stall_cnt = 0;
    int         t_mark    = 0;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.out_valid && cap_n < CAP) begin
            cap_data[cap_n] = bus.data_out;
            cap_sd[cap_n]   = bus.start_data;
            cap_sof[cap_n]  = bus.start_of_frame;
            cap_eof[cap_n]  = bus.end_of_frame;
            cap_cyc[cap_n]  = cyc;
            cap_n           = cap_n + 1;
        end
        if (bus.frame_err) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int i, input int w);
        int y;
        int x;
        y = i / w;
        x = i % w;
        return 8'((16 * y + x) % 256);
    endfunction

    // Raster index of the k-th block-ordered output of a frame of width w.
    function automatic int blk_to_raster(input int k, input int w);
        int s;
        int rem;
        int bx;
        int p;
        s   = k / (B * w);
        rem = k % (B * w);
        bx  = rem / (B * B);
        p   = rem % (B * B);
        return (B * s + p / B) * w + B * bx + p % B;
    endfunction

    // Drive the first npix pixels of a w x h frame; SOF on pixel 0.
    task automatic send(input int w, input int h, input bit gaps, input int npix);
        int n;
        int budget;
        bit v;
        n      = 0;
        budget = 0;
        bus.frame_width  = 16'(w);
        bus.frame_height = 16'(h);
        while (n < npix && budget < 20000) begin
            @(negedge clk);
            budget++;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = pix(n, w);
            bus.in_sof   = (n == 0);
            if (!bus.in_ready) stall_cnt++;
            if (v && bus.in_ready) begin
                if (n == B * w - 1) t_mark = cyc;
                n++;
            end
        end
        chk("send_accepted", n, npix);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic wait_outputs(input int target);
        int budget;
        budget = 0;
        while (cap_n < target && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        repeat (20) @(negedge clk);
    endtask

    // Compare a captured frame against exp_px reordered into blocks.
    task automatic check_frame(input int base, input int w, input int h);
        int ri;
        chk("out_count", cap_n - base, w * h);
        for (int k = 0; k < w * h; k++) begin
            ri = blk_to_raster(k, w);
            chk($sformatf("data[%0d]", k), int'(cap_data[base + k]), int'(exp_px[ri]));
            chk($sformatf("start_data[%0d]", k), int'(cap_sd[base + k]),
                int'(k % (B * B) == 0));
            chk($sformatf("sof[%0d]", k), int'(cap_sof[base + k]), int'(k == 0));
            chk($sformatf("eof[%0d]", k), int'(cap_eof[base + k]), int'(k == w * h - 1));
            if (k % (B * B) == B * B - 1) begin
                chk($sformatf("block_span[%0d]", k / (B * B)),
                    cap_cyc[base + k] - cap_cyc[base + k - (B * B - 1)], B * B - 1);
            end
        end
    endtask

    vec_t tab [10];
    int   base;
    int   err0;
    int   exp_err;

    initial begin
        // Hand-computed 16x16 block-order points: {index, value, start_data, sof, eof}.
        tab[0] = '{0,   8'd0,   1'b1, 1'b1, 1'b0};
        tab[1] = '{7,   8'd7,   1'b0, 1'b0, 1'b0};
        tab[2] = '{8,   8'd16,  1'b0, 1'b0, 1'b0};
        tab[3] = '{63,  8'd119, 1'b0, 1'b0, 1'b0};
        tab[4] = '{64,  8'd8,   1'b1, 1'b0, 1'b0};
        tab[5] = '{127, 8'd127, 1'b0, 1'b0, 1'b0};
        tab[6] = '{128, 8'd128, 1'b1, 1'b0, 1'b0};
        tab[7] = '{192, 8'd136, 1'b1, 1'b0, 1'b0};
        tab[8] = '{200, 8'd152, 1'b0, 1'b0, 1'b0};
        tab[9] = '{255, 8'd255, 1'b0, 1'b0, 1'b1};

        bus.frame_width  = 16'd16;
        bus.frame_height = 16'd16;
        bus.in_valid     = 1'b0;
        bus.in_data      = 8'd0;
        bus.in_sof       = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_start_data", int'(bus.start_data), 0);
        chk("rst_sof", int'(bus.start_of_frame), 0);
        chk("rst_eof", int'(bus.end_of_frame), 0);
        chk("rst_bpf", int'(bus.blocks_per_frame), 0);
        chk("rst_frame_err", int'(bus.frame_err), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(bus.in_ready), 1);

        // 16x16 continuous.
        for (int i = 0; i < 256; i++) exp_px[i] = pix(i, 16);
        base = cap_n;
        send(16, 16, 1'b0, 256);
        wait_outputs(base + 256);
        chk("bpf_16x16", int'(bus.blocks_per_frame), 4);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tab_data[%0d]", tab[i].idx), int'(cap_data[base + tab[i].idx]),
                int'(tab[i].data));
            chk($sformatf("tab_sd[%0d]", tab[i].idx), int'(cap_sd[base + tab[i].idx]),
                int'(tab[i].sd));
            chk($sformatf("tab_sof[%0d]", tab[i].idx), int'(cap_sof[base + tab[i].idx]),
                int'(tab[i].sof));
            chk($sformatf("tab_eof[%0d]", tab[i].idx), int'(cap_eof[base + tab[i].idx]),
                int'(tab[i].eof));
        end
        check_frame(base, 16, 16);

        // 32x16 continuous: no stalls, first output two cycles after input index 255.
        for (int i = 0; i < 512; i++) exp_px[i] = pix(i, 32);
        base      = cap_n;
        stall_cnt = 0;
        send(32, 16, 1'b0, 512);
        wait_outputs(base + 512);
        chk("stalls_32x16", stall_cnt, 0);
        chk("latency_32x16", cap_cyc[base] - t_mark, 2);
        chk("bpf_32x16", int'(bus.blocks_per_frame), 8);
        check_frame(base, 32, 16);

        // 16x16 with random input gaps.
        for (int i = 0; i < 256; i++) exp_px[i] = pix(i, 16);
        base = cap_n;
        send(16, 16, 1'b1, 256);
        wait_outputs(base + 256);
        check_frame(base, 16, 16);

        // Reset during block 1 output, then an 8x8 frame.
        send(16, 16, 1'b0, 200);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        chk("midrst_bpf", int'(bus.blocks_per_frame), 0);
        chk("midrst_data_out", int'(bus.data_out), 0);
        for (int i = 0; i < 64; i++) exp_px[i] = pix(i, 8);
        base = cap_n;
        send(8, 8, 1'b0, 64);
        wait_outputs(base + 64);
        chk("bpf_8x8", int'(bus.blocks_per_frame), 1);
        check_frame(base, 8, 8);

        // SOF at input index 40 of a 16x16 frame.
        err0 = err_cnt;
        base = cap_n;
`ifdef RASTER_TO_BLOCK_SOF_CHECK_EN
        exp_err = 1;
        for (int i = 0; i < 256; i++) exp_px[i] = pix(i, 16);
`else
        exp_err = 0;
        for (int i = 0; i < 256; i++) exp_px[i] = (i < 40) ? pix(i, 16) : pix(i - 40, 16);
`endif
        send(16, 16, 1'b0, 40);
        send(16, 16, 1'b0, 256);
        wait_outputs(base + 256);
        chk("frame_err_pulses", err_cnt - err0, exp_err);
        chk("bpf_resof", int'(bus.blocks_per_frame), 4);
        check_frame(base, 16, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/raster_to_block.md
# raster_to_block

Raster-to-block reorder stage directly upstream of the single-channel Wiener filter. It accepts one channel of pixels in raster order and buffers BLOCK_SIZE image rows (one strip) in ping-pong line memories. It then emits the strip as BLOCK_SIZE×BLOCK_SIZE blocks, each on TOTAL_SAMPLES consecutive cycles, with the framing pulses and `blocks_per_frame` value the Wiener stage consumes.

## Interface
- `DATA_WIDTH`, 8, pixel width.
- `BLOCK_SIZE`, 8, block edge in pixels; power of 2. TOTAL_SAMPLES = BLOCK_SIZE².
- `MAX_WIDTH`, 1024, maximum frame width in pixels; sizes each bank.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `frame_width` in 16: pixels per line; sampled when `in_sof` is accepted.
- `frame_height` in 16: lines per frame; sampled when `in_sof` is accepted.
- `in_valid` in 1: input pixel valid.
- `in_ready` out 1: block accepts a pixel; handshake = `in_valid & in_ready`.
- `in_data` in DATA_WIDTH: input pixel.
- `in_sof` in 1: qualifies the accepted pixel as pixel (0,0) of a frame.
- `data_out` out DATA_WIDTH: block-ordered pixel.
- `out_valid` out 1: `data_out` valid.
- `start_data` out 1: pulse with pixel 0 of every block.
- `start_of_frame` out 1: pulse with pixel 0 of block 0 of the frame.
- `end_of_frame` out 1: pulse with the last pixel of the last block.
- `blocks_per_frame` out 32: (W/BLOCK_SIZE)·(H/BLOCK_SIZE).
- `frame_err` out 1: mid-frame SOF pulse. Active only with the macro.

## Operation
- Two banks, each BLOCK_SIZE × MAX_WIDTH. At any time one bank is the write bank and the other is the read bank.
- Write FSM:
  - W_IDLE: wait for an accepted pixel with `in_sof`=1. Latch W/H, compute `blocks_per_frame`, write the pixel to row 0 col 0, go to W_FILL. Pixels accepted in W_IDLE without `in_sof` are dropped.
  - W_FILL: write at (row, col); col wraps at W-1 and row increments. After row BLOCK_SIZE-1, col W-1, hand the bank to the reader.
    - If the reader is idle: swap banks and stay in W_FILL, or go to W_IDLE if this was the last strip.
    - Otherwise go to W_WAIT.
  - W_WAIT: `in_ready`=0. On reader release, swap banks and go to W_FILL (or W_IDLE if the frame's last strip has been written).
- Read FSM:
  - R_IDLE → R_STREAM on bank handoff.
  - In R_STREAM, issue one read address per cycle in block order: bx = 0..W/B-1; within a block, row-major r = 0..B-1, c = 0..B-1; address (r, bx·B+c).
  - Reader releases its bank in the cycle it issues the last address of the strip.
- A handoff and a reader release in the same cycle swap banks immediately, with no stall.
- Output flags are pipelined alongside the read address, so they align with `data_out`.
- Strip counter and block counter count to H/B and W/B. `end_of_frame` marks the final block of the final strip.
- `blocks_per_frame` holds its value until the next accepted SOF.
- W and H must be nonzero multiples of BLOCK_SIZE, and W ≤ MAX_WIDTH. Otherwise behaviour is undefined.

## Timing
- Reset values:
  - `in_ready`=0, then 1 starting the first cycle after `rst` deasserts.
  - `out_valid`, `data_out`, `start_data`, `start_of_frame`, `end_of_frame`, `frame_err` = 0.
  - `blocks_per_frame` = 0.
  - Both FSMs idle; all counters cleared.
- `rst` mid-stream: the next cycle, all outputs take their reset values. Buffered data is discarded.
- Latency: if the last pixel of a strip is accepted at cycle T and the reader is idle, the first block pixel appears at T+2 (registered RAM read).
- Each block occupies exactly TOTAL_SAMPLES consecutive `out_valid` cycles. Blocks within a strip follow each other back-to-back. There is no output backpressure.
- With continuous input, `in_ready` never deasserts after the first strip, because read and write rates are equal.

## Configuration
- `RASTER_TO_BLOCK_SOF_CHECK_EN` defined:
  - An accepted `in_sof` while the write FSM is not at (0,0) of a new frame pulses `frame_err` for 1 cycle.
  - The reader aborts: `out_valid` drops the next cycle and no `end_of_frame` is issued.
  - The pixel is taken as (0,0) of a new frame, with W/H resampled.
- Not defined:
  - `in_sof` is sampled only in W_IDLE; mid-frame `in_sof` is ignored.
  - `frame_err` is tied to 0.

## Test plan
- 16×16 frame, B=8, `in_data`=(16y+x) mod 256, continuous input:
  - `blocks_per_frame`=4 and 256 outputs.
  - Block 0 is 0..7, 16..23, …, 112..119; block 1 starts at 8.
  - `start_data` at output indices 0, 64, 128, 192.
  - `start_of_frame` at index 0 and `end_of_frame` at index 255.
- Width 32, height 16, continuous input: `in_ready` stays 1 after reset release, and the first output appears 2 cycles after input index 255.
- Random `in_valid` gaps on a 16×16 frame: output order is identical to the first test, and each block is 64 contiguous `out_valid` cycles.
- `rst` asserted for 1 cycle during block 1 output: next cycle `out_valid`=0 and `in_ready`=0. A following 8×8 frame outputs 64 pixels, with `blocks_per_frame`=1.
- With the macro, `in_sof` at input index 40 of a 16×16 frame: `frame_err` pulses once and the new frame outputs correctly. Without the macro, `frame_err` stays 0 and the original frame completes.
